prm_edge_mask_accum: RTL and testbench
======================================

// Module: prm_edge_mask_accum
// PURPOSE
//  Downstream collector for the bank of per-edge obstacle checkers (prm_oblgc_chk*).
//  Streams 15-bit obstacle voxel codes from the scene loader into the checker bank.
//  ORs each returned edge_mask vector into a per-scene "edge blocked" bitmap.
//  At end of scene, drains the bitmap word-serially to the roadmap graph search.
// PARAMETERS
//  NUM_EDGES  512  roadmap edges = checker instances; must be a multiple of WORD_W
//  CODE_W     15   voxel code width (checker inputs A..O; A = bit 0, O = bit 14)
//  WORD_W     32   drain word width; NWORDS = NUM_EDGES/WORD_W, IDX_W = $clog2(NWORDS)
// PORTS
//  clk           in   1          system clock
//  rst_n         in   1          async active-low reset
//  scene_start   in   1          1-cycle pulse: clear bitmap, start new scene
//  vox_valid     in   1          voxel code valid
//  vox_ready     out  1          accumulator accepts voxel
//  vox_code      in   CODE_W     obstacle voxel code
//  vox_last      in   1          qualifies final voxel of scene
//  chk_code      out  CODE_W     registered code driven to all checker inputs
//  edge_mask_in  in   NUM_EDGES  checker outputs; bit e = edge e collides with chk_code
//  out_valid     out  1          drain word valid
//  out_ready     in   1          consumer accepts word
//  out_word      out  WORD_W     bitmap slice [out_idx*WORD_W +: WORD_W]; 1 = blocked
//  out_idx       out  IDX_W      word index
//  out_last      out  1          high with final word (out_idx == NWORDS-1)
//  busy          out  1          state != IDLE
// BEHAVIOUR
//  Reset: all outputs, bitmap, chk_code, p_valid, p_last, idx = 0; state IDLE.
//  States: IDLE, ACCUM, FLUSH, DRAIN.
//  - IDLE: vox_ready=0, out_valid=0. scene_start -> clear bitmap, idx=0, ACCUM.
//  - ACCUM: vox_ready=1. On vox_valid&vox_ready: chk_code<=vox_code, p_valid<=1,
//    p_last<=vox_last; otherwise p_valid<=0. Accepting vox_last -> FLUSH.
//  - Every cycle with p_valid=1 (any state): bitmap <= bitmap | edge_mask_in.
//    edge_mask_in is ignored when p_valid=0.
//    Latency: voxel accepted at cycle t, its mask is merged at edge t+1,
//    and is visible in the bitmap at t+2.
//  - FLUSH (1 cycle): vox_ready=0; merges last voxel's mask; -> DRAIN.
//  - DRAIN: out_valid=1; out_word/out_idx from idx; out_ready advances idx.
//    out_valid&out_ready&out_last -> IDLE, idx=0. Word stable while out_ready=0.
//  - Back-to-back voxels: one per cycle, no bubbles. vox_valid low inserts gaps.
//  - A scene has >= 1 voxel. vox_last on the first voxel is legal.
//  - scene_start in ACCUM/FLUSH/DRAIN aborts the scene:
//    clear bitmap, p_valid<=0, idx<=0, -> ACCUM.
//    It wins over a same-cycle voxel accept, which is dropped.
//    It wins over an in-flight merge: the cleared bitmap holds no stale bits.
//  - Bitmap is sticky within a scene: no bit clears except via scene_start/reset.
//  - Async reset mid-scene: immediate return to reset values.
//  - chk_code holds its last value when idle.
// CONFIGURATION
//  PRM_EDGE_MASK_COUNT_EN defined:
//    adds output blocked_cnt [$clog2(NUM_EDGES+1)-1:0], reset 0.
//    Counts newly set bits per merge: += popcount(edge_mask_in & ~bitmap).
//    Cleared with the bitmap; valid (final) from the FLUSH->DRAIN transition.
//  Undefined: no port, no popcount logic.
// TESTING
//  1 start, 1 voxel, last=1, mask bit 216 set -> drain word 6 = 0x0100_0000,
//    other 15 words 0; out_last only on idx 15; count=1 if EN.
//  2 3 voxels back-to-back, masks {bit0}, {bit0,bit511}, {bit33} -> word0=0x1,
//    word1=0x2, word15=0x8000_0000; count=3.
//  3 out_ready toggled 1/0 during drain -> each word held until accepted;
//    16 handshakes total, then IDLE, busy=0.
//  4 scene_start in the same cycle as a voxel accept during ACCUM ->
//    voxel dropped, bitmap 0; the next scene's voxels alone appear in the drain.
//  5 rst_n low mid-DRAIN at idx 7 -> out_valid=0, vox_ready=0, busy=0 immediately;
//    a new scene then drains from idx 0.
//  6 Voxel gaps (vox_valid low) with edge_mask_in toggling garbage ->
//    garbage never merged; only p_valid cycles contribute.

Source files
------------

// File: rtl/prm_edge_mask_accum.sv
// Voxel streamer and edge-blocked bitmap accumulator for the PRM checker bank.
// Optional blocked-edge counter enabled by defining PRM_EDGE_MASK_COUNT_EN.
module prm_edge_mask_accum #(
    parameter int NUM_EDGES = 512,
    parameter int CODE_W    = 15,
    parameter int WORD_W    = 32,
    localparam int NWORDS   = NUM_EDGES / WORD_W,
    localparam int IDX_W    = $clog2(NWORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scene_start,
    input  logic                 vox_valid,
    output logic                 vox_ready,
    input  logic [CODE_W-1:0]    vox_code,
    input  logic                 vox_last,
    output logic [CODE_W-1:0]    chk_code,
    input  logic [NUM_EDGES-1:0] edge_mask_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_word,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
    output logic                 busy
`ifdef PRM_EDGE_MASK_COUNT_EN
    ,
    output logic [$clog2(NUM_EDGES+1)-1:0] blocked_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [NUM_EDGES-1:0]         r_bitmap;
    logic [CODE_W-1:0]            r_chk_code;
    logic                         r_p_valid;
    logic                         r_p_last;
    logic [IDX_W-1:0]             r_idx;
    logic [NWORDS-1:0][WORD_W-1:0] w_words;
    logic                         w_accept;
    logic                         w_out_hs;
    logic                         w_idx_last;

    assign vox_ready  = (r_state == S_ACCUM);
    assign out_valid  = (r_state == S_DRAIN);
    assign busy       = (r_state != S_IDLE);
    assign w_idx_last = (r_idx == IDX_W'(NWORDS - 1));
    assign out_last   = out_valid && w_idx_last;
    assign out_idx    = r_idx;
    assign chk_code   = r_chk_code;
    assign w_words    = r_bitmap;
    assign out_word   = w_words[r_idx];

    // scene_start beats a same-cycle accept; the voxel is dropped
    assign w_accept   = vox_valid && vox_ready && !scene_start;
    assign w_out_hs   = out_valid && out_ready;

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE:  w_state_n = S_IDLE;
            S_ACCUM: begin
                if (w_accept && vox_last)
                    w_state_n = S_FLUSH;
            end
            S_FLUSH: w_state_n = r_p_last ? S_DRAIN : S_ACCUM;
            S_DRAIN: begin
                if (w_out_hs && w_idx_last)
                    w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
        if (scene_start)
            w_state_n = S_ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitmap   <= '0;
            r_chk_code <= '0;
            r_p_valid  <= 1'b0;
            r_p_last   <= 1'b0;
            r_idx      <= '0;
        end else if (scene_start) begin
            // an in-flight merge is discarded with the old scene
            r_bitmap  <= '0;
            r_p_valid <= 1'b0;
            r_idx     <= '0;
        end else begin
            if (r_p_valid)
                r_bitmap <= r_bitmap | edge_mask_in;
            if (w_accept) begin
                r_chk_code <= vox_code;
                r_p_valid  <= 1'b1;
                r_p_last   <= vox_last;
            end else begin
                r_p_valid  <= 1'b0;
            end
            if (w_out_hs)
                r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
        end
    end

`ifdef PRM_EDGE_MASK_COUNT_EN
    localparam int CNT_W = $clog2(NUM_EDGES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_new_bits;

    always_comb begin
        w_new_bits = '0;
        for (int i = 0; i < NUM_EDGES; i++)
            w_new_bits = w_new_bits +
                CNT_W'(edge_mask_in[i] & ~r_bitmap[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (scene_start)
            r_cnt <= '0;
        else if (r_p_valid)
            r_cnt <= r_cnt + w_new_bits;
    end

    assign blocked_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Directed scoreboard bench for prm_edge_mask_accum.
module tb_prm_edge_mask_accum;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         scene_start;
    logic         vox_valid;
    logic         vox_ready;
    logic [14:0]  vox_code;
    logic         vox_last;
    logic [14:0]  chk_code;
    logic [511:0] edge_mask_in;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_word;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         busy;
`ifdef PRM_EDGE_MASK_COUNT_EN
    logic [9:0]   blocked_cnt;
`endif

    always #5 clk = ~clk;

    prm_edge_mask_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scene_start  (scene_start),
        .vox_valid    (vox_valid),
        .vox_ready    (vox_ready),
        .vox_code     (vox_code),
        .vox_last     (vox_last),
        .chk_code     (chk_code),
        .edge_mask_in (edge_mask_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy)
`ifdef PRM_EDGE_MASK_COUNT_EN
        ,
        .blocked_cnt  (blocked_cnt)
`endif
    );

    typedef struct {
        logic [31:0] word;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t         exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [511:0] m_bm;
    logic [511:0] pend_mask;
    logic         pend;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] garb();
        logic [511:0] g;
        for (int i = 0; i < 16; i++)
            g[i*32 +: 32] = $urandom;
        return g;
    endfunction

    function automatic logic [511:0] bit1(input int b);
        logic [511:0] r;
        r = '0;
        r[b] = 1'b1;
        return r;
    endfunction

    function automatic int popc(input logic [511:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 512; i++)
            n += int'(v[i]);
        return n;
    endfunction

    // mask presented one cycle after accept; garbage otherwise
    task automatic cur_mask();
        edge_mask_in = pend ? pend_mask : garb();
    endtask

    task automatic start_scene(input logic v);
        scene_start = 1'b1;
        vox_valid   = v;
        vox_code    = 15'h2abc;
        vox_last    = 1'b0;
        cur_mask();
        @(negedge clk);
        scene_start = 1'b0;
        vox_valid   = 1'b0;
        pend        = 1'b0;
        m_bm        = '0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_vox_ready", 64'(vox_ready), 64'd1);
    endtask

    task automatic step(input logic v, input logic [14:0] c,
                        input logic l, input logic [511:0] m);
        logic acc;
        vox_valid = v;
        vox_code  = c;
        vox_last  = l;
        cur_mask();
        acc = v && vox_ready;
        @(negedge clk);
        vox_valid = 1'b0;
        pend      = acc;
        pend_mask = m;
        if (acc) begin
            m_bm |= m;
            chk("chk_code", 64'(chk_code), 64'(c));
        end
    endtask

    task automatic finish_scene();
        step(1'b0, 15'h0, 1'b0, '0);
        chk("drain_entry_valid", 64'(out_valid), 64'd1);
        chk("drain_entry_ready", 64'(vox_ready), 64'd0);
`ifdef PRM_EDGE_MASK_COUNT_EN
        chk("blocked_cnt", 64'(blocked_cnt), 64'(popc(m_bm)));
`endif
        for (int i = 0; i < 16; i++)
            exp_q.push_back('{m_bm[i*32 +: 32], 4'(i), (i == 15)});
    endtask

    task automatic drain(input bit toggle, input int max_hs, output int hs);
        int cyc;
        exp_t e;
        hs  = 0;
        cyc = 0;
        while (hs < max_hs && cyc < 200) begin
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            edge_mask_in = garb();
            chk("drain_valid", 64'(out_valid), 64'd1);
            if (exp_q.size() == 0) begin
                chk("drain_queue_empty", 64'(exp_q.size()), 64'd1);
                break;
            end
            e = exp_q[0];
            chk("out_word", 64'(out_word), 64'(e.word));
            chk("out_idx", 64'(out_idx), 64'(e.idx));
            chk("out_last", 64'(out_last), 64'(e.last));
            if (out_ready) begin
                void'(exp_q.pop_front());
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_handshakes", 64'(hs), 64'(max_hs));
    endtask

    initial begin
        int hs;
        rst_n        = 1'b0;
        scene_start  = 1'b0;
        vox_valid    = 1'b0;
        vox_code     = '0;
        vox_last     = 1'b0;
        edge_mask_in = '0;
        out_ready    = 1'b0;
        pend         = 1'b0;
        pend_mask    = '0;
        m_bm         = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_vox_ready", 64'(vox_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_chk_code", 64'(chk_code), 64'd0);
        chk("rst_out_word", 64'(out_word), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
`ifdef PRM_EDGE_MASK_COUNT_EN
        chk("rst_cnt", 64'(blocked_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // single voxel, bit 216 -> word 6 = 0x0100_0000
        start_scene(1'b0);
        step(1'b1, 15'h1234, 1'b1, bit1(216));
        finish_scene();
        chk("t1_model_word6", 64'(exp_q[6].word), 64'h0100_0000);
        drain(1'b0, 16, hs);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // back-to-back voxels
        start_scene(1'b0);
        step(1'b1, 15'h0001, 1'b0, bit1(0));
        step(1'b1, 15'h7fff, 1'b0, bit1(0) | bit1(511));
        step(1'b1, 15'h4000, 1'b1, bit1(33));
        finish_scene();
        drain(1'b0, 16, hs);

        // out_ready toggling during drain
        start_scene(1'b0);
        step(1'b1, 15'h0555, 1'b0, bit1(5) | bit1(70));
        step(1'b1, 15'h2aaa, 1'b1, bit1(480));
        finish_scene();
        drain(1'b1, 16, hs);
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_out_valid", 64'(out_valid), 64'd0);

        // abort with a same-cycle voxel and an in-flight merge
        start_scene(1'b0);
        step(1'b1, 15'h0abc, 1'b0, bit1(10) | bit1(400));
        start_scene(1'b1);
        step(1'b1, 15'h0def, 1'b0, bit1(77));
        step(1'b1, 15'h0123, 1'b1, bit1(300));
        finish_scene();
        drain(1'b0, 16, hs);

        // async reset mid-drain at idx 7
        start_scene(1'b0);
        step(1'b1, 15'h3333, 1'b1, bit1(100) | bit1(300));
        finish_scene();
        drain(1'b0, 7, hs);
        chk("t5_idx_before_rst", 64'(out_idx), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_vox_ready", 64'(vox_ready), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_out_word", 64'(out_word), 64'd0);
        exp_q.delete();
        pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // gaps with garbage masks
        start_scene(1'b0);
        step(1'b1, 15'h0011, 1'b0, bit1(1) | bit1(64));
        step(1'b0, 15'h0000, 1'b0, '0);
        step(1'b0, 15'h0000, 1'b0, '0);
        step(1'b1, 15'h0022, 1'b0, bit1(200));
        step(1'b0, 15'h0000, 1'b0, '0);
        step(1'b1, 15'h0033, 1'b1, bit1(505));
        finish_scene();
        chk("t6_first_idx", 64'(out_idx), 64'd0);
        drain(1'b0, 16, hs);
        chk("t6_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
